// File: rtl/header_unpadder.sv
// Receive-side unpadder for one 1024-bit SHA-256 padded block header (32 words).
// Optional in_last framing is enabled by defining HEADER_UNPADDER_LAST_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_COLLECT | accepting words 0..31, filling fields, checking padding tail
// S_OUTPUT  | decoded header and pad_error held until out_ready handshake
module header_unpadder #(
  parameter logic [63:0] EXP_LEN = 64'd640
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
`ifdef HEADER_UNPADDER_LAST_EN
  input  logic         in_last,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  version,
  output logic [255:0] prev_block_hash,
  output logic [255:0] merkle_root,
  output logic [31:0]  timestamp,
  output logic [31:0]  bits,
  output logic [31:0]  nonce,
  output logic         pad_error
);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_OUTPUT  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        pad_error_q, pad_error_d;
  logic [31:0] words_q [20];
  logic [31:0] words_d [20];

  logic        xfer;
  logic        tail_bad;
  logic        err_acc;
  logic        cnt_last;

  assign xfer     = in_valid && (state_q == S_COLLECT);
  assign cnt_last = (cnt_q == 5'd31);

  always_comb begin
    tail_bad = 1'b0;
    if (cnt_q == 5'd20) begin
      tail_bad = (in_data != 32'h8000_0000);
    end else if (cnt_q >= 5'd21 && cnt_q <= 5'd29) begin
      tail_bad = (in_data != 32'h0000_0000);
    end else if (cnt_q == 5'd30) begin
      tail_bad = (in_data != EXP_LEN[63:32]);
    end else if (cnt_q == 5'd31) begin
      tail_bad = (in_data != EXP_LEN[31:0]);
    end
  end

  // Word 0 starts a fresh frame, so the accumulated error restarts there.
  assign err_acc = ((cnt_q == 5'd0) ? 1'b0 : err_q) | tail_bad;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    pad_error_d = pad_error_q;
    words_d     = words_q;

    case (state_q)
      S_COLLECT: begin
        if (xfer) begin
          for (int i = 0; i < 20; i++) begin
            if (cnt_q == 5'(i)) begin
              words_d[i] = in_data;
            end
          end
          cnt_d = cnt_q + 5'd1;
          err_d = err_acc;
`ifdef HEADER_UNPADDER_LAST_EN
          // Any disagreement between in_last and the word count is a framing error.
          if (in_last || cnt_last) begin
            state_d     = S_OUTPUT;
            cnt_d       = 5'd0;
            pad_error_d = err_acc | (in_last ^ cnt_last);
          end
`else
          if (cnt_last) begin
            state_d     = S_OUTPUT;
            cnt_d       = 5'd0;
            pad_error_d = err_acc;
          end
`endif
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_COLLECT;
      cnt_q       <= 5'd0;
      err_q       <= 1'b0;
      pad_error_q <= 1'b0;
      words_q     <= '{default: 32'h0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      pad_error_q <= pad_error_d;
      words_q     <= words_d;
    end
  end

  assign in_ready        = (state_q == S_COLLECT);
  assign out_valid       = (state_q == S_OUTPUT);
  assign version         = words_q[0];
  assign prev_block_hash = {words_q[1], words_q[2], words_q[3], words_q[4],
                            words_q[5], words_q[6], words_q[7], words_q[8]};
  assign merkle_root     = {words_q[9],  words_q[10], words_q[11], words_q[12],
                            words_q[13], words_q[14], words_q[15], words_q[16]};
  assign timestamp       = words_q[17];
  assign bits            = words_q[18];
  assign nonce           = words_q[19];
  assign pad_error       = pad_error_q;

endmodule

// File: tb/tb_header_unpadder.sv
// Scoreboard bench for header_unpadder: expected headers are queued as frames are
// built and popped when the decoded header appears on the output.
module tb_header_unpadder;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = 32'h0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [31:0]  version;
  logic [255:0] prev_block_hash;
  logic [255:0] merkle_root;
  logic [31:0]  timestamp;
  logic [31:0]  bits;
  logic [31:0]  nonce;
  logic         pad_error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc0_cyc = 0;

  logic [640:0] sb [$];
  logic [640:0] e;
  logic [31:0]  frame_w [32];

  logic [31:0]  version_v = 32'h2000_0000;
  logic [255:0] prev_v    = 256'h1;
  logic [255:0] merkle_v  = {8'hAB, {30{8'h5A}}, 8'hCD};
  logic [31:0]  ts_v      = 32'h5F5E_1000;
  logic [31:0]  bits_v    = 32'h1D00_FFFF;

  wire [640:0] obs = {version, prev_block_hash, merkle_root, timestamp, bits, nonce, pad_error};

  header_unpadder dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
`ifdef HEADER_UNPADDER_LAST_EN
    .in_last         (in_last),
`endif
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .version         (version),
    .prev_block_hash (prev_block_hash),
    .merkle_root     (merkle_root),
    .timestamp       (timestamp),
    .bits            (bits),
    .nonce           (nonce),
    .pad_error       (pad_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic build_frame(input logic [31:0] nonce_v, input logic [31:0] w20,
                             input logic [31:0] w31, input logic perr, input bit push);
    frame_w[0] = version_v;
    for (int i = 0; i < 8; i++) begin
      frame_w[1 + i] = prev_v[255 - 32*i -: 32];
      frame_w[9 + i] = merkle_v[255 - 32*i -: 32];
    end
    frame_w[17] = ts_v;
    frame_w[18] = bits_v;
    frame_w[19] = nonce_v;
    frame_w[20] = w20;
    for (int i = 21; i < 31; i++) frame_w[i] = 32'h0;
    frame_w[31] = w31;
    if (push) sb.push_back({version_v, prev_v, merkle_v, ts_v, bits_v, nonce_v, perr});
  endtask

  // Drives one word and returns #1 after the edge on which it was accepted.
  task automatic send_word(input logic [31:0] w, input logic last);
    bit done;
    int n;
    in_valid = 1'b1;
    in_data  = w;
    in_last  = last;
    done = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout in_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic send_frame(input bit gap, input int last_at);
    for (int i = 0; i < 32; i++) begin
      send_word(frame_w[i], i == last_at);
      if (i == 0) acc0_cyc = cyc;
      if (gap) begin
        @(posedge clk);
        #1;
      end
      if (i == last_at) break;
    end
  endtask

  task automatic release_hdr();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (pad_error !== 1'b0) begin bad++; $display("FAIL rst_pad_error got=%b exp=0", pad_error); end
    total++; if (obs !== 641'h0) begin bad++; $display("FAIL rst_fields got=%h exp=0", obs); end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back_single();
    build_frame(32'h1234_5678, 32'h8000_0000, 32'h0000_0280, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      send_word(frame_w[i], i == 31);
      if (i == 30) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t1_early_valid got=%b exp=0", out_valid); end
      end
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t1_latency out_valid got=%b exp=1", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL t1_in_ready_held got=%b exp=0", in_ready); end
    e = sb.pop_front();
    total++; if (obs !== e) begin bad++; $display("FAIL t1_hdr got=%h exp=%h", obs, e); end
    release_hdr();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL t1_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_gaps_stall();
    build_frame(32'h1234_5678, 32'h8000_0000, 32'h0000_0280, 1'b0, 1'b1);
    send_frame(1'b1, 31);
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t2_valid_c%0d got=%b exp=1", k, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL t2_ready_c%0d got=%b exp=0", k, in_ready); end
      total++; if (obs !== e) begin bad++; $display("FAIL t2_hdr_c%0d got=%h exp=%h", k, obs, e); end
      @(posedge clk);
      #1;
    end
    release_hdr();
  endtask

  task automatic test_pad_errors();
    logic [31:0] w20 [3];
    logic [31:0] w31 [3];
    logic        pe  [3];
    w20 = '{32'h0000_0080, 32'h8000_0000, 32'h8000_0000};
    w31 = '{32'h0000_0280, 32'h0000_0200, 32'h0000_0280};
    pe  = '{1'b1, 1'b1, 1'b0};
    for (int f = 0; f < 3; f++) begin
      build_frame(32'hC0DE_0000 + f, w20[f], w31[f], pe[f], 1'b1);
      send_frame(1'b0, 31);
      e = sb.pop_front();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t3_valid_f%0d got=%b exp=1", f, out_valid); end
      total++; if (obs !== e) begin bad++; $display("FAIL t3_hdr_f%0d got=%h exp=%h", f, obs, e); end
      release_hdr();
    end
  endtask

  task automatic test_reset_midframe();
    build_frame(32'hDEAD_0001, 32'h8000_0000, 32'h0000_0280, 1'b0, 1'b0);
    for (int i = 0; i <= 12; i++) send_word(frame_w[i], 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || pad_error !== 1'b0) begin
      bad++; $display("FAIL t4_after_rst got valid=%b ready=%b perr=%b exp 0 1 0", out_valid, in_ready, pad_error);
    end
    build_frame(32'hBEEF_0002, 32'h8000_0000, 32'h0000_0280, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      send_word(frame_w[i], i == 31);
      if (i == 30) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t4_spurious_valid got=%b exp=0", out_valid); end
      end
    end
    e = sb.pop_front();
    total++; if (obs !== e || out_valid !== 1'b1) begin
      bad++; $display("FAIL t4_hdr got=%h valid=%b exp=%h valid=1", obs, out_valid, e);
    end
    release_hdr();
    // A header pending in OUTPUT is dropped by reset.
    build_frame(32'hBEEF_0003, 32'h8000_0000, 32'h0000_0280, 1'b0, 1'b0);
    send_frame(1'b0, 31);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t4_pending got=%b exp=1", out_valid); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL t4_drop got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int rise_cyc;
    rise_cyc = 0;
    out_ready = 1'b1;
    fork
      begin
        build_frame(32'h1111_1111, 32'h8000_0000, 32'h0000_0280, 1'b0, 1'b1);
        send_frame(1'b0, 31);
        build_frame(32'h2222_2222, 32'h8000_0000, 32'h0000_0280, 1'b0, 1'b1);
        send_frame(1'b0, 31);
      end
      begin
        for (int f = 0; f < 2; f++) begin
          int n;
          n = 0;
          while (!out_valid && n < 300) begin
            @(posedge clk);
            #1;
            n++;
          end
          total++;
          if (!out_valid) begin
            bad++; $display("FAIL t5_wait_f%0d out_valid got=0 exp=1", f);
          end else begin
            if (f == 0) rise_cyc = cyc;
            e = sb.pop_front();
            if (obs !== e) begin bad++; $display("FAIL t5_hdr_f%0d got=%h exp=%h", f, obs, e); end
          end
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b0;
    total++; if (acc0_cyc - rise_cyc < 2) begin
      bad++; $display("FAIL t5_bubble word0 gap got=%0d exp>=2", acc0_cyc - rise_cyc);
    end
  endtask

`ifdef HEADER_UNPADDER_LAST_EN
  task automatic test_last();
    int  last_at [3];
    logic pe     [3];
    last_at = '{19, 31, 99};
    pe      = '{1'b1, 1'b0, 1'b1};
    for (int f = 0; f < 3; f++) begin
      build_frame(32'h5555_0000 + f, 32'h8000_0000, 32'h0000_0280, pe[f], 1'b1);
      send_frame(1'b0, last_at[f]);
      e = sb.pop_front();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t6_valid_f%0d got=%b exp=1", f, out_valid); end
      total++; if (obs !== e) begin bad++; $display("FAIL t6_hdr_f%0d got=%h exp=%h", f, obs, e); end
      release_hdr();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back_single();
    test_gaps_stall();
    test_pad_errors();
    test_reset_midframe();
    test_back_to_back();
`ifdef HEADER_UNPADDER_LAST_EN
    test_last();
`endif
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
